scan_relock_ctrl: RTL and testbench

- Parametrised relock sequencer for the lock-in/PID lock chain.
- When lock is lost and relock is enabled, it freezes the PIDs and centres a triangular scan on the last scan_A value. The scan span doubles each scan period from a programmable start size up to a programmable maximum.
- Adds what the fixed-size sequencer lacks: runtime init/max span, a retry budget, lock confirmation before success, abort on disable, and a relock event counter.
- Drives the gen_scan limits and the PID freeze lines.

---
 rtl/scan_relock_ctrl.sv | 141 ++++++++++++++
 tb/tb_scan_relock_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_relock_ctrl.sv
// scan_relock_ctrl: relock sequencer that widens a centred triangular scan until lock returns
module scan_relock_ctrl #(
    parameter int R = 14,
    parameter int WAIT_BITS = 3,
    parameter int CONF_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 relock_on,
    input  logic                 out_of_lock,
    input  logic signed [R-1:0]  scan_A,
    input  logic                 scan_trigger_in,
    input  logic                 sm_reset,
    input  logic [3:0]           size_init_log2,
    input  logic [3:0]           size_max_log2,
    input  logic [3:0]           retries,
    input  logic [CONF_BITS-1:0] lock_confirm,
    output logic signed [R-1:0]  new_low_lim,
    output logic signed [R-1:0]  new_hig_lim,
    output logic [3:0]           state_code,
    output logic                 run_scan,
    output logic                 freeze_pids,
    output logic                 failed,
    output logic [15:0]          relock_cnt
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SET_SIZE = 4'd1,
        WAIT     = 4'd2,
        SCAN     = 4'd3,
        CONFIRM  = 4'd4,
        SUCCESS  = 4'd5,
        FAIL     = 4'd6
    } state_t;

    localparam int MAXL = R - 2;

    state_t               state, state_nx;
    logic [R-1:0]         scan_size, max_size, init_size, dbl_size;
    logic signed [R-1:0]  scan_a_val;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic [CONF_BITS-1:0] conf_cnt;
    logic [3:0]           retry_cnt, eff_max, eff_init;
    logic                 first, trig_q, trig_qq, trig, abort, at_max;
    logic [R:0]           low_ext, hig_ext;

    // wraps an R+1 bit result back into R bits, saturating on overflow
    function automatic logic [R-1:0] sat(input logic [R:0] v);
        return (v[R] == v[R-1]) ? v[R-1:0] : {v[R], {(R-1){~v[R]}}};
    endfunction

    // half-span never exceeds 2^(R-2), so the limits stay within one saturation step
    assign eff_max   = (int'(size_max_log2) > MAXL) ? 4'(MAXL) : size_max_log2;
    assign eff_init  = (size_init_log2 > eff_max) ? eff_max : size_init_log2;
    assign max_size  = R'(1) << eff_max;
    assign init_size = R'(1) << eff_init;
    assign dbl_size  = scan_size << 1;
    assign at_max    = scan_size >= max_size;
    assign trig      = trig_q & ~trig_qq;
    assign abort     = (state != IDLE) & (sm_reset | ~relock_on);

    assign low_ext     = {scan_a_val[R-1], scan_a_val} - {1'b0, scan_size};
    assign hig_ext     = {scan_a_val[R-1], scan_a_val} + {1'b0, scan_size};
    assign new_low_lim = sat(low_ext);
    assign new_hig_lim = sat(hig_ext);
    assign state_code  = state;
    assign run_scan    = (state == SET_SIZE) | (state == WAIT) | (state == SCAN);
    assign freeze_pids = (state != IDLE) & (state != CONFIRM);
    assign failed      = state == FAIL;

    // next-state selection; an abort request overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (relock_on & out_of_lock & ~sm_reset) ? SET_SIZE : IDLE;
            SET_SIZE: state_nx = WAIT;
            WAIT:     state_nx = (&wait_cnt) ? SCAN : WAIT;
            SCAN:     state_nx = !out_of_lock ? CONFIRM :
                                 !trig ? SCAN :
                                 (!at_max || retry_cnt != 4'd0) ? SET_SIZE : FAIL;
            CONFIRM:  state_nx = out_of_lock ? WAIT :
                                 (conf_cnt >= lock_confirm) ? SUCCESS : CONFIRM;
            SUCCESS:  state_nx = IDLE;
            FAIL:     state_nx = FAIL;
            default:  state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end

    // state register, trigger edge detector and per-state datapath updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scan_size  <= '0;
            scan_a_val <= '0;
            wait_cnt   <= '0;
            conf_cnt   <= '0;
            retry_cnt  <= '0;
            relock_cnt <= '0;
            first      <= 1'b1;
            trig_q     <= 1'b0;
            trig_qq    <= 1'b0;
        end else begin
            state   <= state_nx;
            trig_q  <= scan_trigger_in;
            trig_qq <= trig_q;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        scan_a_val <= scan_A;
                        first      <= 1'b1;
                        retry_cnt  <= retries;
                    end
                    SET_SIZE: begin
                        scan_size <= first ? init_size : (dbl_size > max_size ? max_size : dbl_size);
                        first     <= 1'b0;
                        wait_cnt  <= '0;
                    end
                    WAIT: wait_cnt <= wait_cnt + 1'b1;
                    SCAN: begin
                        if (!out_of_lock)
                            conf_cnt <= '0;
                        else if (trig && at_max && retry_cnt != 4'd0) begin
                            retry_cnt <= retry_cnt - 1'b1;
                            first     <= 1'b1;
                        end
                    end
                    CONFIRM: begin
                        if (out_of_lock)
                            wait_cnt <= '0;
                        else if (conf_cnt < lock_confirm)
                            conf_cnt <= conf_cnt + 1'b1;
                    end
                    SUCCESS: relock_cnt <= (&relock_cnt) ? relock_cnt : relock_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_relock_ctrl.sv
// tb_scan_relock_ctrl: directed and random checks of the relock sequencer against a behavioural model
module tb_scan_relock_ctrl;
    localparam int WAIT_LEN = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               relock_on = 1'b0, out_of_lock = 1'b0, scan_trigger_in = 1'b0, sm_reset = 1'b0;
    logic signed [13:0] scan_a = '0;
    logic [3:0]         size_init_log2 = '0, size_max_log2 = '0, retries = '0;
    logic [15:0]        lock_confirm = '0;
    logic signed [13:0] low_lim, hig_lim;
    logic [3:0]         state_code;
    logic               run_scan, freeze_pids, failed;
    logic [15:0]        relock_cnt;

    int checks = 0, failures = 0;
    int m_st, m_size, m_cen, m_left, m_conf, m_retry, m_first, m_cnt, t1, t2;
    int ool_hold = 0;

    always #5 clk = ~clk;

    scan_relock_ctrl dut (
        .clk(clk), .rst(rst), .relock_on(relock_on), .out_of_lock(out_of_lock),
        .scan_A(scan_a), .scan_trigger_in(scan_trigger_in), .sm_reset(sm_reset),
        .size_init_log2(size_init_log2), .size_max_log2(size_max_log2), .retries(retries),
        .lock_confirm(lock_confirm), .new_low_lim(low_lim), .new_hig_lim(hig_lim),
        .state_code(state_code), .run_scan(run_scan), .freeze_pids(freeze_pids),
        .failed(failed), .relock_cnt(relock_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return v > 8191 ? 8191 : (v < -8192 ? -8192 : v);
    endfunction

    task automatic model_reset();
        m_st = 0; m_size = 0; m_cen = 0; m_left = 0; m_conf = 0;
        m_retry = 0; m_first = 1; m_cnt = 0; t1 = 0; t2 = 0;
    endtask

    task automatic model_step();
        int emax, eint, maxs, ns;
        bit pulse;
        pulse = (t1 == 1) && (t2 == 0);
        emax = (size_max_log2 > 12) ? 12 : int'(size_max_log2);
        eint = (int'(size_init_log2) > emax) ? emax : int'(size_init_log2);
        maxs = 1 << emax;
        ns = m_st;
        if (m_st != 0 && (sm_reset || !relock_on)) ns = 0;
        else begin
            case (m_st)
                0: begin
                    m_cen = int'(scan_a); m_first = 1; m_retry = int'(retries);
                    if (relock_on && out_of_lock && !sm_reset) ns = 1;
                end
                1: begin
                    m_size = m_first ? (1 << eint) : ((2 * m_size < maxs) ? 2 * m_size : maxs);
                    m_first = 0; m_left = WAIT_LEN; ns = 2;
                end
                2: begin
                    m_left--;
                    if (m_left == 0) ns = 3;
                end
                3: begin
                    if (!out_of_lock) begin ns = 4; m_conf = 0; end
                    else if (pulse) begin
                        if (m_size < maxs) ns = 1;
                        else if (m_retry > 0) begin m_retry--; m_first = 1; ns = 1; end
                        else ns = 6;
                    end
                end
                4: begin
                    if (out_of_lock) begin ns = 2; m_left = WAIT_LEN; end
                    else if (m_conf >= int'(lock_confirm)) ns = 5;
                    else m_conf++;
                end
                5: begin
                    if (m_cnt < 65535) m_cnt++;
                    ns = 0;
                end
                6: ;
                default: ns = 0;
            endcase
        end
        t2 = t1;
        t1 = int'(scan_trigger_in);
        m_st = ns;
    endtask

    task automatic compare_all();
        chk("state", int'(state_code), m_st);
        chk("low_lim", int'(low_lim), clamp(m_cen - m_size));
        chk("hig_lim", int'(hig_lim), clamp(m_cen + m_size));
        chk("run_scan", int'(run_scan), int'(m_st >= 1 && m_st <= 3));
        chk("freeze_pids", int'(freeze_pids), int'(m_st != 0 && m_st != 4));
        chk("failed", int'(failed), int'(m_st == 6));
        chk("relock_cnt", int'(relock_cnt), m_cnt);
    endtask

    task automatic tick();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_state(input string tag, input int code);
        for (int i = 0; i < 40 && int'(state_code) != code; i++) tick();
        chk(tag, int'(state_code), code);
    endtask

    task automatic pulse_trig();
        scan_trigger_in = 1'b1;
        tick();
        scan_trigger_in = 1'b0;
        tick();
    endtask

    initial begin
        int spans[3];
        int per, hl;
        spans = '{8, 16, 32};
        repeat (3) tick();
        chk("reset_state", int'(state_code), 0);
        chk("reset_low", int'(low_lim), 0);
        chk("reset_hig", int'(hig_lim), 0);
        rst = 1'b0;
        // basic doubling to max, then FAIL
        size_init_log2 = 4'd3; size_max_log2 = 4'd5; retries = 4'd0; lock_confirm = 16'd0;
        scan_a = 14'sd100; out_of_lock = 1'b1; relock_on = 1'b1;
        tick();
        chk("t1_set_size", int'(state_code), 1);
        wait_state("t1_scan", 3);
        chk("t1_low8", int'(low_lim), 92);
        chk("t1_hig8", int'(hig_lim), 108);
        pulse_trig();
        wait_state("t1_scan16", 3);
        chk("t1_low16", int'(low_lim), 84);
        chk("t1_hig16", int'(hig_lim), 116);
        pulse_trig();
        wait_state("t1_scan32", 3);
        chk("t1_low32", int'(low_lim), 68);
        chk("t1_hig32", int'(hig_lim), 132);
        pulse_trig();
        chk("t1_fail_state", int'(state_code), 6);
        chk("t1_failed", int'(failed), 1);
        chk("t1_run_scan", int'(run_scan), 0);
        sm_reset = 1'b1;
        tick();
        chk("t1_idle", int'(state_code), 0);
        sm_reset = 1'b0;
        // retry budget: three full sweeps, then FAIL
        retries = 4'd2;
        wait_state("t2_scan0", 3);
        for (int k = 0; k < 9; k++) begin
            chk("t2_span", (int'(hig_lim) - int'(low_lim)) / 2, spans[k % 3]);
            pulse_trig();
            if (k < 8) wait_state("t2_scan", 3);
        end
        chk("t2_fail", int'(state_code), 6);
        // saturation at the positive rail
        sm_reset = 1'b1; scan_a = 14'sd8100; size_init_log2 = 4'd12; size_max_log2 = 4'd12; retries = 4'd0;
        tick();
        sm_reset = 1'b0;
        wait_state("t3_scan", 3);
        chk("t3_hig_sat", int'(hig_lim), 8191);
        chk("t3_low", int'(low_lim), 4004);
        // confirm, lock loss during confirm, then success
        sm_reset = 1'b1; scan_a = 14'sd100; size_init_log2 = 4'd3; size_max_log2 = 4'd5; lock_confirm = 16'd10;
        tick();
        sm_reset = 1'b0;
        wait_state("t4_scan8", 3);
        pulse_trig();
        wait_state("t4_scan16", 3);
        out_of_lock = 1'b0;
        tick();
        chk("t4_confirm", int'(state_code), 4);
        chk("t4_run_scan", int'(run_scan), 0);
        chk("t4_freeze", int'(freeze_pids), 0);
        repeat (3) tick();
        out_of_lock = 1'b1;
        tick();
        chk("t4_rewait", int'(state_code), 2);
        wait_state("t4_rescan", 3);
        chk("t4_low16", int'(low_lim), 84);
        chk("t4_hig16", int'(hig_lim), 116);
        out_of_lock = 1'b0;
        tick();
        repeat (10) tick();
        chk("t4_conf_last", int'(state_code), 4);
        tick();
        chk("t4_success", int'(state_code), 5);
        tick();
        chk("t4_idle", int'(state_code), 0);
        chk("t4_relock_cnt", int'(relock_cnt), 1);
        // disable coincident with a trigger pulse, then a held trigger level
        out_of_lock = 1'b1;
        wait_state("t5_scan", 3);
        scan_trigger_in = 1'b1;
        tick();
        relock_on = 1'b0;
        tick();
        chk("t5_abort", int'(state_code), 0);
        chk("t5_freeze", int'(freeze_pids), 0);
        chk("t5_relock_cnt", int'(relock_cnt), 1);
        scan_trigger_in = 1'b0;
        relock_on = 1'b1;
        wait_state("t5_scan8", 3);
        scan_trigger_in = 1'b1;
        repeat (20) tick();
        chk("t5_held_state", int'(state_code), 3);
        chk("t5_held_span", (int'(hig_lim) - int'(low_lim)) / 2, 16);
        scan_trigger_in = 1'b0;
        // random segments with fresh settings each time
        for (int seg = 0; seg < 25; seg++) begin
            size_init_log2 = 4'($urandom_range(0, 15));
            size_max_log2 = 4'($urandom_range(0, 15));
            retries = 4'($urandom_range(0, 3));
            lock_confirm = 16'($urandom_range(0, 12));
            per = $urandom_range(12, 40);
            hl = $urandom_range(1, 3);
            if (seg == 12) begin
                rst = 1'b1;
                repeat (2) tick();
                rst = 1'b0;
            end
            for (int c = 0; c < 160; c++) begin
                scan_trigger_in = (c % per) < hl;
                if (ool_hold == 0) begin
                    out_of_lock = ~out_of_lock;
                    ool_hold = out_of_lock ? $urandom_range(20, 120) : $urandom_range(1, 20);
                end else ool_hold--;
                relock_on = $urandom_range(0, 99) != 0;
                sm_reset = $urandom_range(0, 199) == 0;
                scan_a = 14'($urandom);
                tick();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
